// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: round-robin arbiter for 16 requesters sharing one datapath slot.
// One requester owns the slot at a time. A grant is held until the owner pulses
// done, drops its request, En falls, or the optional hold limit expires. The
// search start index then moves to just below the last winner, wrapping 0 -> 15,
// so every requester is eventually served.
// CW must be wide enough to hold HOLD_MAX-1. The counter saturates at 2^CW-1.
module rr_arbiter_16 #(
  parameter int HOLD_MAX = 255,
  parameter int CW       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        En,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_id,
  output logic        VALID,
  output logic        tmo
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // The hold counter counts 0,1,2,... starting from the first grant cycle.
  // The counter value HOLD_MAX-1 marks the last cycle the grant may stay high.
  localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_MAX == 0) ? 0 : (HOLD_MAX - 1));
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam bit            TMO_EN    = (HOLD_MAX != 0);

  // Architectural state
  state_t        state_reg;
  logic [3:0]    ptr_reg;
  logic [CW-1:0] cnt_reg;
  logic [15:0]   gnt_reg;
  logic [3:0]    gnt_id_reg;
  logic          valid_reg;
  logic          tmo_reg;

  // Winner search
  logic [15:0]   rot_req;
  logic          any_req;
  logic [3:0]    win_off;
  logic [3:0]    win_id;
  logic [15:0]   win_onehot;

  // Release decode
  logic          owner_req;
  logic          rel_done;
  logic          rel_drop;
  logic          rel_en;
  logic          rel_tmo;
  logic          release_now;
  logic          tmo_only;
  logic [CW-1:0] cnt_next;

  // rot_req[k] is the request at search offset k, i.e. from requester ptr-k.
  // Offset 0 has the highest priority, so the downward rotation becomes a
  // plain lowest-set-bit search.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rot
      localparam logic [3:0] OFF = 4'(gi);
      logic [3:0] idx;
      assign idx         = ptr_reg - OFF;
      assign rot_req[gi] = req[idx];
    end
  endgenerate

  // Find the smallest offset with a pending request.
  // The loop runs downward so that the last hit, which is the lowest offset, wins.
  always_comb begin
    any_req = 1'b0;
    win_off = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (rot_req[k]) begin
        any_req = 1'b1;
        win_off = 4'(k);
      end
    end
  end

  // Convert the winning offset back to an absolute requester index (mod 16).
  assign win_id = ptr_reg - win_off;

  // One-hot form of the winner, loaded straight into the grant register.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_onehot
      localparam logic [3:0] IDX = 4'(gi);
      assign win_onehot[gi] = (win_id == IDX);
    end
  endgenerate

  // Release causes while in GRANT.
  // tmo is flagged only when the timeout is the sole reason for the release.
  assign owner_req   = req[gnt_id_reg];
  assign rel_done    = done;
  assign rel_drop    = ~owner_req;
  assign rel_en      = ~En;
  assign rel_tmo     = TMO_EN && (cnt_reg == HOLD_LAST);
  assign release_now = rel_done | rel_drop | rel_en | rel_tmo;
  assign tmo_only    = rel_tmo & ~rel_done & ~rel_drop & ~rel_en;

  // The hold counter saturates instead of wrapping.
  // This keeps an unlimited hold (HOLD_MAX = 0) from aliasing back to zero.
  assign cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : (cnt_reg + CW'(1));

  // Arbiter FSM with registered grant outputs. Reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      ptr_reg    <= 4'd15;
      cnt_reg    <= '0;
      gnt_reg    <= 16'h0000;
      gnt_id_reg <= 4'd0;
      valid_reg  <= 1'b0;
      tmo_reg    <= 1'b0;
    end else begin
      tmo_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (En && any_req) begin
            state_reg  <= GRANT;
            gnt_reg    <= win_onehot;
            gnt_id_reg <= win_id;
            valid_reg  <= 1'b1;
            cnt_reg    <= '0;
            ptr_reg    <= win_id - 4'd1;
          end
        end
        GRANT: begin
          if (release_now) begin
            // gnt_id keeps the last owner so downstream logic can still see it.
            state_reg <= IDLE;
            gnt_reg   <= 16'h0000;
            valid_reg <= 1'b0;
            tmo_reg   <= tmo_only;
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 16'h0000;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign gnt    = gnt_reg;
  assign gnt_id = gnt_id_reg;
  assign VALID  = valid_reg;
  assign tmo    = tmo_reg;

endmodule
